// File: rtl/instruction_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_queue
//  Purpose  : Sequential instruction fetcher feeding a small circular queue.
//             A three-state FSM (FETCH / HOLD / FLUSH) issues reads to the
//             instruction memory, pushes {pc, instruction} pairs into the
//             queue, and handles jump/branch redirects with a one-cycle
//             bubble. The queue head is presented combinationally downstream.
//  Ports    :
//     CLK                       in   clock, all state changes on rising edge
//     RESET                     in   synchronous active-high reset
//     instruction_mem_busywait  in   memory not ready (read data invalid)
//     instruction_mem_readdata  in   fetched word
//     instruction_mem_read      out  fetch request
//     instruction_mem_address   out  fetch address
//     jump_branch_signal        in   redirect pulse
//     Jump_Branch_PC            in   redirect target
//     stall                     in   downstream not accepting, holds head
//     instruction_valid         out  queue head valid
//     INSTRUCTION               out  instruction at queue head
//     PC                        out  address of INSTRUCTION
//     INCREMENTED_PC_by_four    out  PC + PC_INCR (modulo 2^XLEN)
//  Revision : 1.0  initial release
// ============================================================================
module instruction_fetch_queue #(
   parameter int              XLEN         = 32,
   parameter int              DEPTH        = 4,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              PC_INCR      = 4
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            instruction_mem_busywait,
   input  logic [XLEN-1:0] instruction_mem_readdata,
   output logic            instruction_mem_read,
   output logic [XLEN-1:0] instruction_mem_address,
   input  logic            jump_branch_signal,
   input  logic [XLEN-1:0] Jump_Branch_PC,
   input  logic            stall,
   output logic            instruction_valid,
   output logic [XLEN-1:0] INSTRUCTION,
   output logic [XLEN-1:0] PC,
   output logic [XLEN-1:0] INCREMENTED_PC_by_four
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
   localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
   localparam logic [XLEN-1:0]  c_pc_incr  = XLEN'(PC_INCR);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t           state_q,    state_d;
   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
   logic [CNT_W-1:0] count_q,    count_d;

   // Queue storage: no reset needed, entries are only visible while counted.
   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [XLEN-1:0] instr_mem [DEPTH];

   logic push;
   logic pop;
   logic [XLEN-1:0] head_pc;

   // ------------------------------------------------------------------------
   // Push / pop qualification. A redirect discards any read completing in the
   // same cycle and overrides any pop, since the whole queue is dropped.
   // ------------------------------------------------------------------------
   always_comb begin
      push = 1'b0;
      pop  = 1'b0;
      push = (state_q == ST_FETCH) && !instruction_mem_busywait &&
             (count_q != c_full_cnt) && !jump_branch_signal && !RESET;
      pop  = (count_q != '0) && !stall && !jump_branch_signal;
   end

   // ------------------------------------------------------------------------
   // Next-state and datapath update
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;

      if (jump_branch_signal) begin
         // Redirect from any state: drop everything, one bubble cycle follows.
         state_d    = ST_FLUSH;
         fetch_pc_d = Jump_Branch_PC;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push) begin
            wr_ptr_d   = wr_ptr_q + c_ptr_one;
            fetch_pc_d = fetch_pc_q + c_pc_incr;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + c_cnt_one;
            2'b01:   count_d = count_q - c_cnt_one;
            default: count_d = count_q;
         endcase

         case (state_q)
            ST_FETCH: begin
               if ((count_d == c_full_cnt) && !pop) begin
                  state_d = ST_HOLD;
               end
            end
            ST_HOLD: begin
               // Space opens on the pop edge; fetching resumes next cycle.
               if (pop) begin
                  state_d = ST_FETCH;
               end
            end
            ST_FLUSH: begin
               state_d = ST_FETCH;
            end
            default: begin
               state_d = ST_FETCH;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= ST_FETCH;
         fetch_pc_q <= RESET_VECTOR;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         pc_mem[wr_ptr_q]    <= fetch_pc_q;
         instr_mem[wr_ptr_q] <= instruction_mem_readdata;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs. Head fields are forced to zero while the queue is empty so the
   // post-reset and post-flush values are well defined.
   // ------------------------------------------------------------------------
   assign instruction_mem_read    = (state_q == ST_FETCH);
   assign instruction_mem_address = fetch_pc_q;

   assign instruction_valid      = (count_q != '0);
   assign head_pc                = instruction_valid ? pc_mem[rd_ptr_q] : '0;
   assign PC                     = head_pc;
   assign INSTRUCTION            = instruction_valid ? instr_mem[rd_ptr_q] : '0;
   assign INCREMENTED_PC_by_four = head_pc + c_pc_incr;

endmodule
`default_nettype wire
